// File: rtl/pong_pkg.sv
// Shared Pong constants, paddle FSM/direction types and the clamped paddle step.
package pong_pkg;

  localparam int unsigned SCREEN_W      = 640;
  localparam int unsigned SCREEN_H      = 480;
  localparam int unsigned PADDLE_H      = 90;
  localparam int unsigned PADDLE_Y_MAX  = SCREEN_H - PADDLE_H;  // 390
  localparam int unsigned PADDLE_Y_INIT = 195;

  // Paddles update one pixel after the ball, so the two never share a cycle.
  localparam int unsigned TICK_X = 639;
  localparam int unsigned TICK_Y = 479;

  typedef enum logic [1:0] {StIdle, StSlow, StFast} paddle_state_e;
  typedef enum logic [1:0] {DirNone, DirUp, DirDown} dir_e;

  // One frame of motion, done at 10 bits so neither direction can wrap.
  function automatic logic [8:0] paddle_step(input logic [8:0] y, input dir_e dir,
                                             input logic [9:0] step);
    logic [9:0] y_w;
    logic [9:0] sum_w;
    logic [9:0] res_w;
    y_w   = {1'b0, y};
    sum_w = y_w + step;
    if (dir == DirUp) begin
      res_w = (y_w < step) ? 10'd0 : y_w - step;
    end else if (dir == DirDown) begin
      res_w = (sum_w > 10'(PADDLE_Y_MAX)) ? 10'(PADDLE_Y_MAX) : sum_w;
    end else begin
      res_w = y_w;
    end
    return 9'(res_w);
  endfunction

endpackage

// File: rtl/paddle_control_if.sv
// Button, scan-position and paddle-position bundle between the board/renderer and paddle_control.
interface paddle_control_if;
  logic       btn_up1;
  logic       btn_dn1;
  logic       btn_up2;
  logic       btn_dn2;
  logic [9:0] o_x;
  logic [8:0] o_y;
  logic [8:0] pos_yBarra1;
  logic [8:0] pos_yBarra2;

  modport master (
    output btn_up1, btn_dn1, btn_up2, btn_dn2, o_x, o_y,
    input  pos_yBarra1, pos_yBarra2
  );

  modport slave (
    input  btn_up1, btn_dn1, btn_up2, btn_dn2, o_x, o_y,
    output pos_yBarra1, pos_yBarra2
  );
endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus stability counter for one raw push button.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk_in,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_level
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES);

  logic [1:0]      r_sync;
  logic [CntW-1:0] r_cnt;
  logic            r_level;

  // Synchronize, then flip the stable level once the input has disagreed long enough.
  always_ff @(posedge clk_in) begin
    if (i_rst) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_btn};
      if (r_sync[1] != r_level) begin
        if (r_cnt == CntMax) begin
          r_level <= ~r_level;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + CntW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/paddle_control.sv
// Debounced buttons drive two paddle FSMs that move once per frame with slow/fast speeds.
module paddle_control
  import pong_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned SPEED_SLOW      = 2,
  parameter int unsigned SPEED_FAST      = 4,
  parameter int unsigned HOLD_FRAMES     = 15
) (
  input logic             clk_in,
  input logic             i_rst,
  paddle_control_if.slave bus
);

  localparam int unsigned HoldW = (HOLD_FRAMES < 16) ? 4 : $clog2(HOLD_FRAMES + 1);

  // Bit order {dn2, up2, dn1, up1}: paddle p uses bits 2p (up) and 2p+1 (down).
  logic [3:0] w_btn_raw;
  logic [3:0] w_btn_lvl;
  logic       w_tick;
  logic [8:0] w_pos [2];

  assign w_btn_raw = {bus.btn_dn2, bus.btn_up2, bus.btn_dn1, bus.btn_up1};
  assign w_tick    = (bus.o_x == 10'(TICK_X)) && (bus.o_y == 9'(TICK_Y));

  for (genvar i = 0; i < 4; i++) begin : g_db
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk_in (clk_in),
      .i_rst  (i_rst),
      .i_btn  (w_btn_raw[i]),
      .o_level(w_btn_lvl[i])
    );
  end

  for (genvar p = 0; p < 2; p++) begin : g_paddle
    dir_e            w_dir;
    paddle_state_e   r_state;
    paddle_state_e   w_state_d;
    logic [HoldW-1:0] r_hold;
    logic [HoldW-1:0] w_hold_d;
    dir_e            r_dir;
    dir_e            w_dir_d;
    logic [8:0]      r_pos;
    logic [8:0]      w_pos_d;
    logic            w_move;

    // Pressing both or neither button means no direction.
    always_comb begin
      w_dir = DirNone;
      if (w_btn_lvl[2*p] && !w_btn_lvl[2*p+1]) begin
        w_dir = DirUp;
      end else if (w_btn_lvl[2*p+1] && !w_btn_lvl[2*p]) begin
        w_dir = DirDown;
      end
    end

    // State register: FSM, hold counter, remembered direction and position.
    always_ff @(posedge clk_in) begin
      if (i_rst) begin
        r_state <= StIdle;
        r_hold  <= '0;
        r_dir   <= DirUp;
        r_pos   <= 9'(PADDLE_Y_INIT);
      end else begin
        r_state <= w_state_d;
        r_hold  <= w_hold_d;
        r_dir   <= w_dir_d;
        r_pos   <= w_pos_d;
      end
    end

    // Next state: direction checks take priority over the frame tick.
    always_comb begin
      w_state_d = r_state;
      w_hold_d  = r_hold;
      w_dir_d   = r_dir;
      w_move    = 1'b0;
      case (r_state)
        StIdle: begin
          if (w_dir != DirNone) begin
            w_state_d = StSlow;
            w_hold_d  = '0;
            w_dir_d   = w_dir;
          end
        end
        StSlow, StFast: begin
          if (w_dir == DirNone) begin
            w_state_d = StIdle;
          end else if (w_dir != r_dir) begin
            w_state_d = StSlow;
            w_hold_d  = '0;
            w_dir_d   = w_dir;
          end else if (w_tick) begin
            w_move = 1'b1;
            if (r_state == StSlow) begin
              w_hold_d = r_hold + HoldW'(1);
              if (w_hold_d == HoldW'(HOLD_FRAMES)) begin
                w_state_d = StFast;
              end
            end
          end
        end
        default: w_state_d = StIdle;
      endcase
    end

    // Output: apply the clamped step at the speed of the current state.
    always_comb begin
      w_pos_d = r_pos;
      if (w_move) begin
        w_pos_d = paddle_step(r_pos, r_dir,
                              (r_state == StFast) ? 10'(SPEED_FAST) : 10'(SPEED_SLOW));
      end
    end

    assign w_pos[p] = r_pos;
  end

  assign bus.pos_yBarra1 = w_pos[0];
  assign bus.pos_yBarra2 = w_pos[1];

endmodule
